hack_comp: RTL and testbench

HACK_COMP -- requirements
Module: hack_comp

---
 rtl/hack_pkg.sv | 33 +++
 rtl/hack_alu.sv | 30 +++
 rtl/hack_comp.sv | 108 ++++++++++
 tb/tb_hack_comp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared constants for the Hack computer: default memory depths and
// instruction field bit positions.
package hack_pkg;

  localparam int unsigned DefInsDepth  = 256;
  localparam int unsigned DefDataDepth = 256;

  // Instruction word layout: [15] C-flag, [12] a, [11:6] zx nx zy ny f no,
  // [5:3] dest A D M, [2:0] jump lt eq gt.
  localparam int unsigned BitCInstr = 15;
  localparam int unsigned BitCHi    = 14;
  localparam int unsigned BitCLo    = 13;
  localparam int unsigned BitA      = 12;
  localparam int unsigned BitZx     = 11;
  localparam int unsigned BitNx     = 10;
  localparam int unsigned BitZy     = 9;
  localparam int unsigned BitNy     = 8;
  localparam int unsigned BitF      = 7;
  localparam int unsigned BitNo     = 6;

  localparam int unsigned BitDestA  = 5;
  localparam int unsigned BitDestD  = 4;
  localparam int unsigned BitDestM  = 3;

  localparam int unsigned BitJLt    = 2;
  localparam int unsigned BitJEq    = 1;
  localparam int unsigned BitJGt    = 0;

  function automatic logic is_c_instr(input logic [15:0] ins);
    return ins[BitCInstr] & ins[BitCHi] & ins[BitCLo];
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Hack ALU: optional zero/negate of each operand, add or AND, optional
// negate of the result, plus zero and negative flags.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z = zx ? 16'h0000 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? 16'h0000 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_comp.sv
// Hack computer: CPU with instruction ROM and data RAM, both loadable through
// external ports while the CPU is held in reset.
module hack_comp
  import hack_pkg::*;
#(
  parameter int unsigned INS_DEPTH  = DefInsDepth,
  parameter int unsigned DATA_DEPTH = DefDataDepth
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_clr,
  input  logic        write_ins,
  input  logic        write_data,
  input  logic        read_data,
  input  logic [15:0] addr_ins,
  input  logic [15:0] dati_ins,
  input  logic [15:0] addr_data,
  input  logic [15:0] dati_data,
  output logic [15:0] dato_data,
  output logic        data_memfull,
  output logic        ins_memfull
);

  localparam int unsigned IAW = (INS_DEPTH > 1) ? $clog2(INS_DEPTH) : 1;
  localparam int unsigned DAW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic [15:0] rom [INS_DEPTH];
  logic [15:0] ram [DATA_DEPTH];

  logic [15:0] a_q, d_q, pc_q;
  logic [15:0] instr, m_val, y_val, alu_out;
  logic        zr, ng;
  logic        pc_in_range, a_in_range, is_c, jump, cpu_wr_m;

  // External port flags and read-back
  always_comb begin
    ins_memfull  = (32'(addr_ins) >= INS_DEPTH);
    data_memfull = (32'(addr_data) >= DATA_DEPTH);
    dato_data    = (read_data && !data_memfull) ? ram[addr_data[DAW-1:0]] : 16'h0000;
  end

  // Fetch and operand selection; out-of-range locations read as zero
  always_comb begin
    pc_in_range = (32'(pc_q) < INS_DEPTH);
    a_in_range  = (32'(a_q) < DATA_DEPTH);
    instr       = pc_in_range ? rom[pc_q[IAW-1:0]] : 16'h0000;
    m_val       = a_in_range ? ram[a_q[DAW-1:0]] : 16'h0000;
    is_c        = is_c_instr(instr);
    y_val       = instr[BitA] ? m_val : a_q;
  end

  hack_alu u_alu (
    .x   (d_q),
    .y   (y_val),
    .zx  (instr[BitZx]),
    .nx  (instr[BitNx]),
    .zy  (instr[BitZy]),
    .ny  (instr[BitNy]),
    .f   (instr[BitF]),
    .no  (instr[BitNo]),
    .out (alu_out),
    .zr  (zr),
    .ng  (ng)
  );

  always_comb begin
    jump = is_c && ((instr[BitJLt] && ng) ||
                    (instr[BitJEq] && zr) ||
                    (instr[BitJGt] && !ng && !zr));
    cpu_wr_m = is_c && instr[BitDestM] && a_in_range;
  end

  // CPU registers; mem_clr deliberately leaves them alone
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 16'h0000;
    end else begin
      pc_q <= jump ? a_q : pc_q + 16'd1;
      if (!instr[BitCInstr]) begin
        a_q <= instr;
      end else if (is_c) begin
        if (instr[BitDestA]) a_q <= alu_out;
        if (instr[BitDestD]) d_q <= alu_out;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_clr) begin
      for (int unsigned i = 0; i < INS_DEPTH; i++) rom[i] <= 16'h0000;
    end else if (reset && write_ins && !ins_memfull) begin
      rom[addr_ins[IAW-1:0]] <= dati_ins;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_clr) begin
      for (int unsigned i = 0; i < DATA_DEPTH; i++) ram[i] <= 16'h0000;
    end else if (reset) begin
      if (write_data && !data_memfull) ram[addr_data[DAW-1:0]] <= dati_data;
    end else if (cpu_wr_m) begin
      ram[a_q[DAW-1:0]] <= alu_out;
    end
  end

endmodule

// File: tb/tb_hack_comp.sv
// Bench for hack_comp: a Hack ISA interpreter tracks RAM contents and is
// compared against the external read port every cycle.
module tb_hack_comp;

  localparam int unsigned InsDepth  = 256;
  localparam int unsigned DataDepth = 256;

  logic        clock = 1'b0;
  logic        reset, mem_clr, write_ins, write_data, read_data;
  logic [15:0] addr_ins, dati_ins, addr_data, dati_data;
  logic [15:0] dato_data;
  logic        data_memfull, ins_memfull;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [15:0] m_rom [InsDepth];
  logic [15:0] m_ram [DataDepth];
  logic [15:0] m_a, m_d, m_pc;

  hack_comp #(
    .INS_DEPTH  (InsDepth),
    .DATA_DEPTH (DataDepth)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_clr      (mem_clr),
    .write_ins    (write_ins),
    .write_data   (write_data),
    .read_data    (read_data),
    .addr_ins     (addr_ins),
    .dati_ins     (dati_ins),
    .addr_data    (addr_data),
    .dati_data    (dati_data),
    .dato_data    (dato_data),
    .data_memfull (data_memfull),
    .ins_memfull  (ins_memfull)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard Hack computation table, indexed by the six ALU control bits
  function automatic logic [15:0] comp(input logic [5:0] c, input logic [15:0] x,
                                       input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return x;
      6'b110000: return y;
      6'b001101: return ~x;
      6'b110001: return ~y;
      6'b001111: return -x;
      6'b110011: return -y;
      6'b011111: return x + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return x - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return x + y;
      6'b010011: return x - y;
      6'b000111: return y - x;
      6'b000000: return x & y;
      6'b010101: return x | y;
      default:   return 16'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] ins, m, y, out, nxt_pc;
    logic        take;
    if (reset) begin
      if (write_ins && addr_ins < InsDepth) m_rom[addr_ins] = dati_ins;
      if (write_data && addr_data < DataDepth) m_ram[addr_data] = dati_data;
      m_a = 0; m_d = 0; m_pc = 0;
    end else begin
      ins = (m_pc < InsDepth) ? m_rom[m_pc] : 16'h0000;
      if (ins[15] == 1'b0) begin
        m_a  = ins;
        m_pc = m_pc + 16'd1;
      end else if (ins[15:13] == 3'b111) begin
        m = (m_a < DataDepth) ? m_ram[m_a] : 16'h0000;
        y = ins[12] ? m : m_a;
        out = comp(ins[11:6], m_d, y);
        take = (ins[2] && $signed(out) < 0) || (ins[1] && out == 0) ||
               (ins[0] && $signed(out) > 0);
        nxt_pc = take ? m_a : m_pc + 16'd1;
        if (ins[3] && m_a < DataDepth) m_ram[m_a] = out;
        if (ins[5]) m_a = out;
        if (ins[4]) m_d = out;
        m_pc = nxt_pc;
      end else begin
        m_pc = m_pc + 16'd1;
      end
    end
    if (mem_clr) begin
      for (int i = 0; i < InsDepth; i++) m_rom[i] = 16'h0000;
      for (int i = 0; i < DataDepth; i++) m_ram[i] = 16'h0000;
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("dato_data", dato_data,
            (read_data && addr_data < DataDepth) ? m_ram[addr_data] : 16'h0000);
      check("data_memfull", {15'd0, data_memfull}, {15'd0, addr_data >= DataDepth});
      check("ins_memfull", {15'd0, ins_memfull}, {15'd0, addr_ins >= InsDepth});
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_rom(input logic [15:0] a, input logic [15:0] v);
    write_ins = 1'b1; addr_ins = a; dati_ins = v;
    tick();
    write_ins = 1'b0; addr_ins = 16'd0;
  endtask

  task automatic wr_ram(input logic [15:0] a, input logic [15:0] v);
    write_data = 1'b1; addr_data = a; dati_data = v;
    tick();
    write_data = 1'b0; addr_data = 16'd2;
  endtask

  task automatic peek(input string name, input logic [15:0] a, input logic [15:0] exp);
    read_data = 1'b1; addr_data = a;
    #1;
    check(name, dato_data, exp);
  endtask

  logic [15:0] max_prog [16] = '{
    16'd0, 16'hFC10, 16'd1, 16'hF4D0, 16'd10, 16'hE301, 16'd1, 16'hFC10,
    16'd12, 16'hEA87, 16'd0, 16'hFC10, 16'd2, 16'hE308, 16'd14, 16'hEA87
  };
  logic [15:0] sum_prog [6] = '{16'd5, 16'hEC10, 16'd10, 16'hE090, 16'd0, 16'hE308};

  initial begin
    m_a = 0; m_d = 0; m_pc = 0;
    for (int i = 0; i < InsDepth; i++) m_rom[i] = 16'h0000;
    for (int i = 0; i < DataDepth; i++) m_ram[i] = 16'h0000;
    reset = 1'b1; mem_clr = 1'b1; write_ins = 1'b0; write_data = 1'b0;
    read_data = 1'b1; addr_ins = 16'd0; dati_ins = 16'd0;
    addr_data = 16'd0; dati_data = 16'd0;
    tick();
    mem_clr = 1'b0;
    chk_en = 1'b1;

    peek("reset_read0", 16'd0, 16'h0000);
    check("reset_memfull", {15'd0, data_memfull}, 16'd0);

    // Max program, RAM[0]=14, RAM[1]=20
    for (int i = 0; i < 16; i++) wr_rom(16'(i), max_prog[i]);
    wr_ram(16'd0, 16'd14);
    wr_ram(16'd1, 16'd20);
    // Out-of-range external writes are dropped
    write_data = 1'b1; addr_data = 16'd256; dati_data = 16'hDEAD;
    #1;
    check("memfull_256", {15'd0, data_memfull}, 16'd1);
    tick();
    write_data = 1'b0;
    write_ins = 1'b1; addr_ins = 16'd300; dati_ins = 16'hBEEF;
    #1;
    check("ins_memfull_300", {15'd0, ins_memfull}, 16'd1);
    tick();
    write_ins = 1'b0; addr_ins = 16'd255;
    #1;
    check("ins_memfull_255", {15'd0, ins_memfull}, 16'd0);
    peek("ram0_intact", 16'd0, 16'd14);
    peek("ram255_intact", 16'd255, 16'd0);

    addr_data = 16'd2;
    reset = 1'b0;
    run(25);
    peek("max_14_20", 16'd2, 16'd20);

    // Same program, RAM[0]=30, RAM[1]=7
    reset = 1'b1;
    tick();
    wr_ram(16'd0, 16'd30);
    wr_ram(16'd1, 16'd7);
    wr_ram(16'd2, 16'd0);
    reset = 1'b0;
    run(25);
    peek("max_30_7", 16'd2, 16'd30);

    // Reset mid-run, then rerun from PC 0
    reset = 1'b1;
    tick();
    wr_ram(16'd2, 16'd0);
    reset = 1'b0;
    run(5);
    reset = 1'b1;
    tick();
    peek("abort_no_write", 16'd2, 16'd0);
    peek("abort_ram0", 16'd0, 16'd30);
    addr_data = 16'd2;
    reset = 1'b0;
    run(25);
    peek("rerun_30_7", 16'd2, 16'd30);

    // mem_clr beats a simultaneous write
    reset = 1'b1;
    mem_clr = 1'b1; write_data = 1'b1; addr_data = 16'd3; dati_data = 16'h1234;
    tick();
    mem_clr = 1'b0; write_data = 1'b0;
    peek("clr_prio", 16'd3, 16'd0);
    peek("clr_ram0", 16'd0, 16'd0);
    peek("clr_ram2", 16'd2, 16'd0);

    // @5 D=A @10 D=D+A @0 M=D
    for (int i = 0; i < 6; i++) wr_rom(16'(i), sum_prog[i]);
    addr_data = 16'd0;
    reset = 1'b0;
    run(10);
    peek("sum_15", 16'd0, 16'd15);
    read_data = 1'b0;
    #1;
    check("read_disabled", dato_data, 16'h0000);
    read_data = 1'b1;

    // Clear after load
    reset = 1'b1;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    peek("post_clr_0", 16'd0, 16'd0);
    read_data = 1'b0;
    #1;
    check("post_clr_rd0", dato_data, 16'h0000);
    read_data = 1'b1;
    run(2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
